io_input_bank: RTL and testbench

Parametrised input-port register bank for the memory-mapped I/O space. It samples NPORTS asynchronous input words through a synchroniser chain and holds each in a data register. Per-bit sticky change flags are cleared on read, and a level interrupt is raised while any flag is pending. It replaces the fixed 4x32 input register plus mux on the I/O read path; the CPU selects words with addr[7:2].

---
 rtl/io_bank_pkg.sv | 11 +
 rtl/io_sync_chain.sv | 21 ++
 rtl/io_input_bank.sv | 68 ++++++
 tb/tb_io_input_bank.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bank_pkg.sv
// io_bank_pkg: word-index map and decode width shared by the input bank
package io_bank_pkg;
  localparam int IDX_W = 6;
  localparam int IDX_DATA_BASE = 0;
  function automatic int idx_flag_base(input int nports);
    return nports;
  endfunction
  function automatic int idx_summary(input int nports);
    return 2 * nports;
  endfunction
endpackage

// File: rtl/io_sync_chain.sv
// io_sync_chain: SYNC_STAGES-deep flop chain bringing one input word into io_clk
module io_sync_chain #(
  parameter int WIDTH = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             io_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  // shift the raw input through the synchroniser stages
  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) r_sync <= '{default: '0};
    else begin
      r_sync[0] <= d;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end
  assign q = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/io_input_bank.sv
// io_input_bank: synchronised input ports with sticky read-to-clear change flags and irq
module io_input_bank
  import io_bank_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NPORTS = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    io_clk,
  input  logic                    reset,
  input  logic [31:0]             addr,
  input  logic                    io_rd,
  input  logic [NPORTS*WIDTH-1:0] in_port,
  output logic [WIDTH-1:0]        io_read_data,
  output logic                    irq
);
  localparam int FB = idx_flag_base(NPORTS);
  localparam int SUM = idx_summary(NPORTS);
  localparam int CW = $clog2(SYNC_STAGES + 2);
  logic [WIDTH-1:0] w_sync [NPORTS];
  logic [WIDTH-1:0] r_data [NPORTS];
  logic [WIDTH-1:0] r_flag [NPORTS];
  logic [WIDTH-1:0] w_flag_nxt [NPORTS];
  logic [WIDTH-1:0] w_summary;
  logic [IDX_W-1:0] w_idx;
  logic [CW-1:0]    r_cnt;
  logic             w_primed, w_any, r_irq;
  genvar g;
  generate
    for (g = 0; g < NPORTS; g++) begin : g_port
      io_sync_chain #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
        .io_clk(io_clk), .reset(reset), .d(in_port[g*WIDTH +: WIDTH]), .q(w_sync[g])
      );
    end
  endgenerate
  assign w_idx = addr[IDX_W+1:2];
  assign w_primed = r_cnt == CW'(SYNC_STAGES + 1);
  // next flag state (clear-on-read first, new changes win), summary, and read mux
  always_comb begin
    io_read_data = '0;
    w_summary = '0;
    w_any = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      w_flag_nxt[i] = ((io_rd && w_idx == IDX_W'(FB + i)) ? '0 : r_flag[i])
                    | (w_primed ? (w_sync[i] ^ r_data[i]) : '0);
      w_summary[i] = |r_flag[i];
      w_any = w_any | (|r_flag[i]);
      io_read_data = (w_idx == IDX_W'(IDX_DATA_BASE + i)) ? r_data[i]
                   : (w_idx == IDX_W'(FB + i)) ? r_flag[i] : io_read_data;
    end
    io_read_data = (w_idx == IDX_W'(SUM)) ? w_summary : io_read_data;
  end
  // data, flags, priming counter; irq follows the flag registers one edge later
  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      r_data <= '{default: '0};
      r_flag <= '{default: '0};
      r_cnt  <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_data <= w_sync;
      r_flag <= w_flag_nxt;
      r_cnt  <= w_primed ? r_cnt : r_cnt + CW'(1);
      r_irq  <= w_any;
    end
  end
  assign irq = r_irq;
endmodule

// File: tb/tb_io_input_bank.sv
// tb_io_input_bank: randomized and directed checks against a history-based model
module tb_io_input_bank;
  localparam int W = 32;
  localparam int NP = 4;
  localparam int SS = 2;
  logic            io_clk, reset, io_rd, irq;
  logic [31:0]     addr;
  logic [NP*W-1:0] in_port;
  logic [W-1:0]    io_read_data;
  int n_pass, n_total;
  logic [NP*W-1:0] m_hist [$];
  logic [W-1:0]    m_data [NP];
  logic [W-1:0]    m_flag [NP];
  logic            m_irq;
  int              m_edges;

  io_input_bank #(.WIDTH(W), .NPORTS(NP), .SYNC_STAGES(SS)) dut (
    .io_clk(io_clk), .reset(reset), .addr(addr), .io_rd(io_rd),
    .in_port(in_port), .io_read_data(io_read_data), .irq(irq)
  );

  initial io_clk = 1'b0;
  always #50 io_clk = ~io_clk;

  task automatic model_reset();
    m_hist = {};
    for (int k = 0; k < SS; k++) m_hist.push_back('0);
    for (int i = 0; i < NP; i++) begin
      m_data[i] = '0;
      m_flag[i] = '0;
    end
    m_irq = 1'b0;
    m_edges = 0;
  endtask

  // value seen SS+1 edges ago becomes visible; flags record changes once primed
  task automatic model_edge();
    logic [NP*W-1:0] nd;
    logic [W-1:0] nw;
    int ix;
    bit pr;
    ix = int'(addr[7:2]);
    m_irq = 1'b0;
    for (int i = 0; i < NP; i++) m_irq = m_irq | (m_flag[i] != 0);
    pr = m_edges >= SS + 1;
    m_hist.push_back(in_port);
    nd = m_hist.pop_front();
    for (int i = 0; i < NP; i++) begin
      nw = nd[i*W +: W];
      if (io_rd && ix == NP + i) m_flag[i] = '0;
      if (pr) m_flag[i] = m_flag[i] | (nw ^ m_data[i]);
      m_data[i] = nw;
    end
    m_edges++;
  endtask

  function automatic logic [W-1:0] exp_read(input int ix);
    logic [W-1:0] s;
    s = '0;
    for (int i = 0; i < NP; i++) s[i] = m_flag[i] != 0;
    if (ix < NP) return m_data[ix];
    if (ix < 2 * NP) return m_flag[ix-NP];
    if (ix == 2 * NP) return s;
    return '0;
  endfunction

  task automatic tick();
    @(posedge io_clk);
    model_edge();
    #1;
  endtask

  task automatic set_port(input int p, input logic [W-1:0] v);
    in_port[p*W +: W] = v;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    io_rd = 1'b1;
    in_port = {$urandom, $urandom, $urandom, $urandom};
    model_reset();
    #20;
    for (int ix = 0; ix < 12; ix++) begin
      addr = (ix == 11 ? 63 : ix) << 2;
      #1;
      n_total++;
      if (io_read_data !== '0) $display("FAIL reset_read idx%0d got %h exp 0", ix, io_read_data);
      else n_pass++;
    end
    n_total++;
    if (irq !== 1'b0) $display("FAIL reset_irq got %b exp 0", irq);
    else n_pass++;
    io_rd = 1'b0;
  endtask

  task automatic test_prime();
    in_port = '0;
    set_port(0, 32'hFFFF_FFFF);
    @(negedge io_clk);
    reset = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      addr = 4 << 2;
      #1;
      n_total++;
      if (io_read_data !== '0 || irq !== 1'b0)
        $display("FAIL prime_noflag edge%0d flag %h irq %b exp 0/0", e, io_read_data, irq);
      else n_pass++;
      if (e == 3) begin
        addr = 0;
        #1;
        n_total++;
        if (io_read_data !== 32'hFFFF_FFFF || io_read_data !== exp_read(0))
          $display("FAIL prime_data got %h exp ffffffff", io_read_data);
        else n_pass++;
      end
    end
  endtask

  task automatic test_change();
    set_port(1, 32'h0000_00A5);
    tick();
    tick();
    tick();
    addr = 1 << 2;
    #1;
    n_total++;
    if (io_read_data !== 32'hA5) $display("FAIL change_data got %h exp a5", io_read_data);
    else n_pass++;
    addr = 5 << 2;
    #1;
    n_total++;
    if (io_read_data !== 32'hA5 || io_read_data !== exp_read(5))
      $display("FAIL change_flag got %h exp a5", io_read_data);
    else n_pass++;
    addr = 8 << 2;
    #1;
    n_total++;
    if (io_read_data !== 32'h2) $display("FAIL change_summary got %h exp 2", io_read_data);
    else n_pass++;
    n_total++;
    if (irq !== 1'b0) $display("FAIL change_irq_lag got %b exp 0", irq);
    else n_pass++;
    tick();
    n_total++;
    if (irq !== 1'b1 || irq !== m_irq) $display("FAIL change_irq got %b exp 1", irq);
    else n_pass++;
  endtask

  task automatic test_clear();
    addr = 5 << 2;
    io_rd = 1'b0;
    tick();
    n_total++;
    if (io_read_data !== 32'hA5) $display("FAIL noclear_rd0 got %h exp a5", io_read_data);
    else n_pass++;
    io_rd = 1'b1;
    #1;
    n_total++;
    if (io_read_data !== 32'hA5) $display("FAIL clear_preval got %h exp a5", io_read_data);
    else n_pass++;
    tick();
    io_rd = 1'b0;
    #1;
    n_total++;
    if (io_read_data !== '0 || io_read_data !== exp_read(5))
      $display("FAIL clear_flag got %h exp 0", io_read_data);
    else n_pass++;
    n_total++;
    if (irq !== 1'b1) $display("FAIL clear_irq_lag got %b exp 1", irq);
    else n_pass++;
    tick();
    n_total++;
    if (irq !== 1'b0 || irq !== m_irq) $display("FAIL clear_irq got %b exp 0", irq);
    else n_pass++;
  endtask

  task automatic test_collide();
    set_port(2, 32'h8);
    tick();
    tick();
    tick();
    set_port(2, 32'h0);
    tick();
    tick();
    addr = 6 << 2;
    io_rd = 1'b1;
    tick();
    io_rd = 1'b0;
    #1;
    n_total++;
    if (io_read_data !== 32'h8 || io_read_data !== exp_read(6))
      $display("FAIL collide_flag got %h exp 8", io_read_data);
    else n_pass++;
    tick();
    n_total++;
    if (irq !== 1'b1) $display("FAIL collide_irq got %b exp 1", irq);
    else n_pass++;
  endtask

  task automatic test_unmapped();
    foreach (m_flag[i]) if (i == 0) m_flag[i] = m_flag[i];
    for (int k = 0; k < 2; k++) begin
      addr = (k == 0 ? 9 : 63) << 2;
      io_rd = 1'b1;
      #1;
      n_total++;
      if (io_read_data !== '0) $display("FAIL unmapped_read idx%0d got %h exp 0", k == 0 ? 9 : 63, io_read_data);
      else n_pass++;
      tick();
    end
    io_rd = 1'b0;
    for (int ix = 0; ix <= 2 * NP; ix++) begin
      addr = ix << 2;
      #1;
      n_total++;
      if (io_read_data !== exp_read(ix)) $display("FAIL unmapped_map idx%0d got %h exp %h", ix, io_read_data, exp_read(ix));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int ix;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NP; p++)
        case ($urandom_range(0, 11))
          0: set_port(p, $urandom);
          1: in_port[p*W + $urandom_range(0, W-1)] ^= 1'b1;
          default: ;
        endcase
      ix = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 2 * NP + 1);
      addr = {$urandom_range(0, 255), 8'h00} | (ix << 2) | $urandom_range(0, 3);
      io_rd = $urandom_range(0, 2) == 0;
      #1;
      n_total++;
      if (io_read_data !== exp_read(ix)) $display("FAIL rand_read c%0d idx%0d got %h exp %h", c, ix, io_read_data, exp_read(ix));
      else n_pass++;
      tick();
      n_total++;
      if (irq !== m_irq) $display("FAIL rand_irq c%0d got %b exp %b", c, irq, m_irq);
      else n_pass++;
    end
    io_rd = 1'b0;
  endtask

  task automatic test_mid_reset();
    set_port(3, ~in_port[3*W +: W]);
    tick();
    tick();
    tick();
    tick();
    #7;
    reset = 1'b1;
    model_reset();
    #1;
    n_total++;
    if (irq !== 1'b0) $display("FAIL midreset_irq got %b exp 0", irq);
    else n_pass++;
    for (int ix = 0; ix <= 2 * NP; ix++) begin
      addr = ix << 2;
      #1;
      n_total++;
      if (io_read_data !== '0) $display("FAIL midreset_read idx%0d got %h exp 0", ix, io_read_data);
      else n_pass++;
    end
    in_port = {$urandom | 32'h1, $urandom, $urandom, $urandom};
    @(negedge io_clk);
    reset = 1'b0;
    addr = 8 << 2;
    for (int e = 1; e <= 4; e++) begin
      tick();
      n_total++;
      if (io_read_data !== '0 || irq !== 1'b0)
        $display("FAIL midreset_prime edge%0d summary %h irq %b exp 0/0", e, io_read_data, irq);
      else n_pass++;
    end
    addr = 3 << 2;
    #1;
    n_total++;
    if (io_read_data !== exp_read(3)) $display("FAIL midreset_data got %h exp %h", io_read_data, exp_read(3));
    else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    addr = '0;
    test_reset();
    test_prime();
    test_change();
    test_clear();
    test_collide();
    test_unmapped();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
